// File: rtl/data_sram_bridge.sv
// rtl/data_sram_bridge.sv - MEM-stage data-side SRAM-like bridge with posted stores and in-order tracking FIFO
module data_sram_bridge #(
  parameter int OUTSTANDING = 2,
  parameter bit KSEG_MAP    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic        MemRead,
  input  logic [1:0]  LoadSize,
  input  logic        LoadSigned,
  input  logic [3:0]  MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        wr_err,
  output logic        stall,
  output logic        CLR
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  function automatic logic [31:0] kseg(input logic [31:0] a);
    if (KSEG_MAP && a[31:30] == 2'b10) return {3'b000, a[28:0]};
    return a;
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  logic [0:0]  state;
  logic        issued;
  logic        cmd_wr, cmd_signed, cmd_killed;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  head, tail;
  logic [2:0]  count;

  logic        f_vld    [0:3];
  logic        f_load   [0:3];
  logic        f_signed [0:3];
  logic        f_killed [0:3];
  logic [1:0]  f_off    [0:3];
  logic [1:0]  f_size   [0:3];

  logic        st_legal;
  logic [1:0]  st_size, st_off;

  always_comb begin
    st_legal = 1'b1;
    st_size  = 2'b00;
    st_off   = 2'b00;
    case (MemWrite)
      4'b0001: st_off = 2'd0;
      4'b0010: st_off = 2'd1;
      4'b0100: st_off = 2'd2;
      4'b1000: st_off = 2'd3;
      4'b0011: st_size = 2'b01;
      4'b1100: begin st_size = 2'b01; st_off = 2'd2; end
      4'b1111: st_size = 2'b10;
      default: st_legal = 1'b0;
    endcase
  end

  logic        op_valid, op_new, is_hold, can_issue, req_idle, accept, pop;
  logic [1:0]  in_off, in_size;
  logic [31:0] in_addr;
  logic        push_load, push_signed, push_killed;
  logic [1:0]  push_off, push_size;
  logic        load_pending, stall_int;

  assign op_valid  = MemRead | ((|MemWrite) & st_legal);
  // issued marks that the op currently held in MEM already went out, so it is not sent twice
  assign op_new    = op_valid & ~issued;
  assign is_hold   = (state == S_HOLD);
  assign can_issue = (count < 3'(OUTSTANDING));
  assign req_idle  = ~is_hold & op_new & can_issue;
  assign accept    = (req_idle | is_hold) & data_addr_ok;
  assign pop       = data_data_ok & (count != 3'd0);

  assign in_off  = MemRead ? addr[1:0] : st_off;
  assign in_size = MemRead ? LoadSize : st_size;
  assign in_addr = kseg({addr[31:2], in_off});

  assign push_load   = is_hold ? ~cmd_wr : MemRead;
  assign push_off    = is_hold ? cmd_addr[1:0] : in_off;
  assign push_size   = is_hold ? cmd_size : in_size;
  assign push_signed = is_hold ? cmd_signed : LoadSigned;
  assign push_killed = flush | (is_hold & cmd_killed);

  always_comb begin
    load_pending = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (f_vld[i] && f_load[i] && !f_killed[i] && !(pop && head == 2'(i)))
        load_pending = 1'b1;
    end
  end

  assign stall_int = ~flush & ((~is_hold & op_new & ~accept) | is_hold |
                               (accept & push_load & ~push_killed) | load_pending);
  assign stall = rst_n & stall_int;
  assign CLR   = stall;

  assign data_req   = rst_n & (req_idle | is_hold);
  assign data_wr    = data_req & (is_hold ? cmd_wr : ~MemRead);
  assign data_size  = data_req ? (is_hold ? cmd_size : in_size) : 2'b00;
  assign data_addr  = data_req ? (is_hold ? cmd_addr : in_addr) : 32'h0;
  assign data_wdata = data_req ? (is_hold ? cmd_wdata : wdata) : 32'h0;

  assign wr_err = rst_n & ~MemRead & (|MemWrite) & ~st_legal;

  logic [31:0] shifted, extended;
  logic        hsg;

  assign shifted = data_rdata >> {f_off[head], 3'b000};
  assign hsg     = f_signed[head];

  always_comb begin
    case (f_size[head])
      2'b00:   extended = {{24{hsg & shifted[7]}}, shifted[7:0]};
      2'b01:   extended = {{16{hsg & shifted[15]}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  assign rdata_valid = rst_n & pop & f_load[head] & ~f_killed[head] & ~flush;
  assign rdata       = rdata_valid ? extended : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      issued     <= 1'b0;
      cmd_wr     <= 1'b0;
      cmd_signed <= 1'b0;
      cmd_killed <= 1'b0;
      cmd_size   <= 2'b00;
      cmd_addr   <= 32'h0;
      cmd_wdata  <= 32'h0;
      head       <= 2'd0;
      tail       <= 2'd0;
      count      <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        f_vld[i]    <= 1'b0;
        f_load[i]   <= 1'b0;
        f_signed[i] <= 1'b0;
        f_killed[i] <= 1'b0;
        f_off[i]    <= 2'd0;
        f_size[i]   <= 2'd0;
      end
    end else begin
      assert (!(data_data_ok && count == 3'd0));
      if (pop) begin
        f_vld[head] <= 1'b0;
        head        <= ptr_inc(head);
      end
      if (flush) begin
        for (int i = 0; i < 4; i++) f_killed[i] <= 1'b1;
      end
      if (accept) begin
        f_vld[tail]    <= 1'b1;
        f_load[tail]   <= push_load;
        f_off[tail]    <= push_off;
        f_size[tail]   <= push_size;
        f_signed[tail] <= push_signed;
        f_killed[tail] <= push_killed;
        tail           <= ptr_inc(tail);
      end
      count  <= count + 3'(accept) - 3'(pop);
      // a killed command completing must not swallow the instruction that follows the flush
      issued <= stall_int & (issued | (accept & ~push_killed));
      case (state)
        S_IDLE: begin
          if (req_idle && !data_addr_ok) begin
            state      <= S_HOLD;
            cmd_wr     <= ~MemRead;
            cmd_size   <= in_size;
            cmd_addr   <= in_addr;
            cmd_wdata  <= wdata;
            cmd_signed <= LoadSigned;
            cmd_killed <= flush;
          end
        end
        default: begin
          if (flush) cmd_killed <= 1'b1;
          if (data_addr_ok) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
